hack_fetch: RTL and testbench
=============================

// Module: hack_fetch
// PURPOSE
//   Instruction fetch stage of the Hack CPU. Owns the program counter and drives the
//   address of the synchronous instruction ROM (registered read, 1-cycle latency).
//   Pairs each returned word with its PC and presents it to decode over a valid/ready
//   handshake. Redirects on jumps, and holds stalled words in a 1-entry skid buffer.
// PARAMETERS
//   WIDTH  16  instruction width; must match ROM WIDTH
//   DEPTH  14  ROM address width; PC width; PC wraps modulo 2**DEPTH
// PORTS
//   clk          in   1      single clock; all state updates on posedge
//   rst          in   1      synchronous, active-high reset
//   rom_addr     out  DEPTH  address to ROM; combinational (ROM registers it)
//   rom_data     in   WIDTH  ROM word for the address issued on the previous cycle
//   jump         in   1      redirect request, this cycle
//   jump_target  in   DEPTH  redirect address, sampled when jump=1
//   instr        out  WIDTH  instruction presented to decode
//   instr_pc     out  DEPTH  address of instr
//   instr_valid  out  1      instr/instr_pc valid
//   instr_ready  in   1      decode accepts when instr_valid & instr_ready
// BEHAVIOUR
//   State: fetch_pc, inflight (word arrives on rom_data this cycle), inflight_pc,
//     skid_valid/skid_data/skid_pc.
//   Reset: fetch_pc=0, inflight=0, skid_valid=0 -> instr_valid=0; rom_addr=0.
//     A reset mid-operation discards in-flight and skid words with no presentation.
//   Output mux (combinational): skid_valid ? skid_* : {rom_data, inflight_pc};
//     instr_valid = skid_valid | inflight. instr and instr_pc are stable while
//     valid & !ready.
//   issue = jump | !(instr_valid & !instr_ready)  (the output slot is free next cycle).
//   rom_addr = jump ? jump_target : fetch_pc.
//   On an issue edge: inflight<=1, inflight_pc<=rom_addr, fetch_pc<=rom_addr+1 (mod 2**DEPTH).
//   No issue: fetch_pc holds. If inflight & !instr_ready, capture
//     {rom_data, inflight_pc} into the skid buffer (skid_valid<=1), inflight<=0.
//   A skid entry is cleared when it is accepted. skid_valid and inflight are never both 1.
//   Steady state with ready=1: one instruction per cycle; first word (pc 0) valid on
//     the cycle after rst falls.
//   Stall release: the held word is accepted, and its successor is valid the next
//     cycle; no bubble, no duplicate, no skip.
//   Jump: a word accepted in the jump cycle counts as consumed. At the edge, skid and
//     inflight words are discarded and the target is issued. The target word is valid
//     the cycle after jump, with instr_pc=jump_target.
//     jump with rst: rst wins.
//   jump_target=2**DEPTH-1: the next fetch wraps to 0.
//   No internal error states; ROM contents are opaque (not decoded here).
// TESTING
//   1 ROM[a]=a^16'hA5A5, ready=1, release rst -> valid rises the next cycle; pc 0,1,2,3
//     on consecutive cycles, instr=pc^A5A5.
//   2 ready=0 for 3 cycles while pc 5 is presented -> instr_pc=5, instr=0xA5A0 held
//     stable; ready=1 -> pc 6 the next cycle, nothing skipped or duplicated.
//   3 jump=1, target=0x0100, in the cycle pc 3 is accepted -> next cycle instr_pc=0x0100;
//     pc 4 is never presented.
//   4 Stall until the skid is full (pc 7 held), then jump to 0x0020 with ready=0 ->
//     pc 7 is dropped; next cycle instr_pc=0x0020, valid=1.
//   5 jump to 0x3FFF, ready=1 -> instr_pc 0x3FFF then 0x0000 on the next cycle.
//   6 rst=1 for 1 cycle while valid=1, ready=0 -> valid=0 the next cycle; after
//     release, the sequence restarts at pc 0 as in test 1.

Source files
------------

// File: rtl/hack_fetch_if.sv
`default_nettype none
//============================================================================
// Module      : hack_fetch_if
// Description : Bus bundle for the Hack fetch stage. It carries the
//               instruction ROM address/data pair, the redirect request
//               from execute, and the valid/ready instruction handshake
//               toward decode.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Signals
//   rom_addr     fetch -> ROM     address; the ROM registers it internally
//   rom_data     ROM   -> fetch   word for the previous cycle's address
//   jump         exec  -> fetch   redirect request, this cycle
//   jump_target  exec  -> fetch   redirect address, used when jump=1
//   instr        fetch -> decode  instruction word
//   instr_pc     fetch -> decode  address of instr
//   instr_valid  fetch -> decode  instr/instr_pc valid
//   instr_ready  decode-> fetch   decode accepts on valid & ready
// Modports
//   master : the fetch stage itself
//   slave  : the environment (ROM, execute, decode)
//============================================================================
interface hack_fetch_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 14
);
    logic [DEPTH-1:0] rom_addr;
    logic [WIDTH-1:0] rom_data;
    logic             jump;
    logic [DEPTH-1:0] jump_target;
    logic [WIDTH-1:0] instr;
    logic [DEPTH-1:0] instr_pc;
    logic             instr_valid;
    logic             instr_ready;

    modport master (
        output rom_addr,
        input  rom_data,
        input  jump,
        input  jump_target,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output jump,
        output jump_target,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready
    );
endinterface
`default_nettype wire

// File: rtl/hack_fetch.sv
`default_nettype none
//============================================================================
// Module      : hack_fetch
// Description : Instruction fetch stage of the Hack CPU. Owns the program
//               counter, drives the synchronous instruction ROM (one cycle
//               read latency), pairs each returned word with its address and
//               hands it to decode over valid/ready. A one-entry skid buffer
//               keeps a word that arrives while decode is stalled, so the ROM
//               pipeline never has to be replayed. Jumps redirect fetch and
//               discard anything not yet accepted.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk   in   single clock, all state updates on the rising edge
//   rst   in   synchronous, active-high reset
//   bus   master modport of hack_fetch_if (ROM, redirect, decode handshake)
//============================================================================
module hack_fetch #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 14
) (
    input  wire logic      clk,
    input  wire logic      rst,
    hack_fetch_if.master   bus
);

    //------------------------------------------------------------------------
    // State
    //------------------------------------------------------------------------
    // fetch_pc     : next sequential address to issue
    // inflight     : a ROM read was issued last cycle; its word is on rom_data
    // inflight_pc  : address of that in-flight word
    // skid_*       : word that arrived while decode was stalled
    logic [DEPTH-1:0] fetch_pc_q,    fetch_pc_d;
    logic             inflight_q,    inflight_d;
    logic [DEPTH-1:0] inflight_pc_q, inflight_pc_d;
    logic             skid_valid_q,  skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,   skid_data_d;
    logic [DEPTH-1:0] skid_pc_q,     skid_pc_d;

    logic             instr_valid_w;
    logic             stall_w;
    logic             issue_w;
    logic [DEPTH-1:0] rom_addr_w;

    //------------------------------------------------------------------------
    // Output side
    //------------------------------------------------------------------------
    // The skid entry, when present, is always older than anything in flight
    // (the two are never both set), so it has priority on the output.
    always_comb begin
        instr_valid_w = skid_valid_q | inflight_q;
        if (skid_valid_q) begin
            bus.instr    = skid_data_q;
            bus.instr_pc = skid_pc_q;
        end else begin
            bus.instr    = bus.rom_data;
            bus.instr_pc = inflight_pc_q;
        end
        bus.instr_valid = instr_valid_w;
    end

    // A word is being held back this cycle.
    assign stall_w = instr_valid_w & ~bus.instr_ready;

    // Issue a new ROM read whenever the output slot will be free next cycle.
    // A jump always frees the slot because it discards whatever is pending.
    assign issue_w = bus.jump | ~stall_w;

    assign rom_addr_w   = bus.jump ? bus.jump_target : fetch_pc_q;
    assign bus.rom_addr = rom_addr_w;

    //------------------------------------------------------------------------
    // Next-state logic
    //------------------------------------------------------------------------
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_data_d   = skid_data_q;
        skid_pc_d     = skid_pc_q;

        if (issue_w) begin
            // Either nothing is pending, the pending word is accepted this
            // cycle, or a jump throws it away: in every case the skid empties
            // and the freshly issued address becomes the in-flight word.
            inflight_d    = 1'b1;
            inflight_pc_d = rom_addr_w;
            fetch_pc_d    = rom_addr_w + DEPTH'(1);
            skid_valid_d  = 1'b0;
        end else begin
            // Stalled without a redirect. The ROM output only lasts one cycle,
            // so an in-flight word must be parked in the skid now. fetch_pc
            // already points past it, so the successor is fetched on release.
            inflight_d = 1'b0;
            if (inflight_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = bus.rom_data;
                skid_pc_d    = inflight_pc_q;
            end
        end
    end

    //------------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            skid_valid_q  <= 1'b0;
            skid_data_q   <= '0;
            skid_pc_q     <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_data_q   <= skid_data_d;
            skid_pc_q     <= skid_pc_d;
        end
    end

    // The single skid entry relies on never holding two words at once.
    a_skid_inflight_exclusive : assert property (
        @(posedge clk) disable iff (rst) !(skid_valid_q && inflight_q)
    );

endmodule
`default_nettype wire

// File: tb/tb_hack_fetch.sv
`default_nettype none
//============================================================================
// Module      : tb_hack_fetch
// Description : Self-checking bench for hack_fetch. A synchronous ROM model
//               holds a^16'hA5A5 at address a. An instruction-stream model
//               predicts which address decode sees each cycle.
// Revision    : 1.0 - initial release
//============================================================================
module tb_hack_fetch;

    localparam int WIDTH = 16;
    localparam int DEPTH = 14;

    logic clk;
    logic rst;

    hack_fetch_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    hack_fetch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests;
    int n_fail;

    // Stream model: is a word presented, and which address is it.
    logic             m_valid;
    logic [DEPTH-1:0] m_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] rom_word(input logic [DEPTH-1:0] a);
        return {2'b00, a} ^ 16'hA5A5;
    endfunction

    // Registered-read ROM.
    always @(posedge clk) bus.rom_data <= rom_word(bus.rom_addr);

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, and
    // compare the DUT outputs half a cycle later.
    task automatic step(input logic r, input logic j,
                        input logic [DEPTH-1:0] t, input logic rdy);
        rst             = r;
        bus.jump        = j;
        bus.jump_target = t;
        bus.instr_ready = rdy;
        @(posedge clk);
        if (r) begin
            m_valid = 1'b0;
            m_pc    = '0;
        end else if (j) begin
            m_valid = 1'b1;
            m_pc    = t;
        end else if (!m_valid) begin
            m_valid = 1'b1;
        end else if (rdy) begin
            m_pc = m_pc + 1'b1;
        end
        @(negedge clk);
        check("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
        if (m_valid) begin
            check("instr_pc", 32'(bus.instr_pc), 32'(m_pc));
            check("instr", 32'(bus.instr), 32'(rom_word(m_pc)));
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1);
        check("reset_rom_addr", 32'(bus.rom_addr), 32'd0);
    endtask

    // Run with ready=1 until the model presents address pc (bounded).
    task automatic run_until(input logic [DEPTH-1:0] pc);
        int n = 0;
        while (!(m_valid && m_pc == pc)) begin
            if (n >= 64) begin
                check("run_until_budget", 32'(n), 32'd0);
                break;
            end
            step(1'b0, 1'b0, '0, 1'b1);
            n++;
        end
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        m_valid         = 1'b0;
        m_pc            = '0;
        rst             = 1'b1;
        bus.jump        = 1'b0;
        bus.jump_target = '0;
        bus.instr_ready = 1'b1;

        // Sequential fetch from reset: pc 0,1,2,3 on consecutive cycles.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
        check("seq_pc3", 32'(bus.instr_pc), 32'd3);

        // Stall on pc 5 for three cycles, then release.
        run_until(14'd5);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, '0, 1'b0);
            check("stall_instr", 32'(bus.instr), 32'hA5A0);
        end
        step(1'b0, 1'b0, '0, 1'b1);
        check("release_pc6", 32'(bus.instr_pc), 32'd6);

        // Jump while pc 3 is accepted.
        do_reset();
        run_until(14'd3);
        step(1'b0, 1'b1, 14'h0100, 1'b1);
        check("jump_pc", 32'(bus.instr_pc), 32'h0100);
        step(1'b0, 1'b0, '0, 1'b1);

        // Jump with the skid full and decode stalled.
        do_reset();
        run_until(14'd7);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 14'h0020, 1'b0);
        check("skid_jump_pc", 32'(bus.instr_pc), 32'h0020);
        step(1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);

        // Wrap at the top of the address space.
        step(1'b0, 1'b1, 14'h3FFF, 1'b1);
        step(1'b0, 1'b0, '0, 1'b1);
        check("wrap_pc", 32'(bus.instr_pc), 32'd0);

        // Reset while a word is held, then restart.
        step(1'b0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b1);
        check("restart_pc3", 32'(bus.instr_pc), 32'd3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic             r;
            logic             j;
            logic [DEPTH-1:0] t;
            logic             rdy;
            r   = ($urandom_range(0, 99) < 2);
            j   = ($urandom_range(0, 99) < 10);
            t   = DEPTH'($urandom);
            rdy = ($urandom_range(0, 99) < 65);
            step(r, j, t, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
